// File: rtl/alu_pipe_hs.sv
// Two-stage ALU pipeline with valid/ready handshaking: stage 1 captures operands and
// opcode, stage 2 executes and registers the result with carry, overflow and zero flags.
module alu_pipe_hs #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [OPW-1:0]   INop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] WD,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_SLTU = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OPW-1:0]   s1_op;

  logic             s1_en;
  logic             s2_en;

  logic             sub_like;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  op_e              op;

  // The output stage frees up whenever it is empty or being drained; stage 1 may load
  // whenever it is empty or stage 2 is about to take its contents.
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  assign op       = op_e'(s1_op);

  // SUB, SLT and SLTU all share the a + ~b + 1 adder so the compares see the true difference.
  assign sub_like = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign b_eff    = sub_like ? ~s1_b : s1_b;
  assign {carry, sum} = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_like};
  assign ovf      = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);

  // NOTE: every signal written in always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_ADD: begin
        alu_res = sum;
        alu_c   = carry;
        alu_v   = ovf;
      end
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_NOR:  alu_res = ~(s1_a | s1_b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, !carry};
      OP_SUB: begin
        alu_res = sum;
        alu_c   = carry;
        alu_v   = ovf;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: alu_res = '0;
    endcase
  end

  // NOTE: registers are assigned with <= so every flop samples the pre-edge values,
  // which is what lets both stages advance in the same cycle without racing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= RD1;
        s1_b  <= RD2;
        s1_op <= INop;
      end
    end
  end

  // Result and flags only move when a valid op enters the output stage, so they stay
  // stable under backpressure and across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      WD        <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        WD   <= alu_res;
        Cout <= alu_c;
        V    <= alu_v;
        Z    <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs: a 32-bit and an 8-bit instance driven with directed and random
// traffic, with results scoreboarded against an arithmetic reference model.
module tb_alu_pipe_hs;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  localparam logic [2:0] AND_OP = 3'b000, ADD_OP = 3'b010, XOR_OP = 3'b011,
                         SLTU_OP = 3'b101, SUB_OP = 3'b110, SLT_OP = 3'b111;

  logic clk = 1'b0;
  logic reset;

  logic        iv32, ir32, ov32, or32, c32, v32, z32;
  logic [31:0] a32, b32, wd32;
  logic [2:0]  op32;

  logic        iv8, ir8, ov8, or8, c8, v8, z8;
  logic [7:0]  a8, b8, wd8;
  logic [2:0]  op8;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q32[$];
  exp_t q8[$];
  int   acc32 = 0;
  logic hold32 = 1'b0, hold8 = 1'b0;
  logic [34:0] held32, held8;

  vec_t vt[4];

  always #5 clk = ~clk;

  alu_pipe_hs #(.WIDTH(32), .OPW(3)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .RD1(a32), .RD2(b32), .INop(op32), .out_valid(ov32), .out_ready(or32),
    .WD(wd32), .Cout(c32), .V(v32), .Z(z32)
  );

  alu_pipe_hs #(.WIDTH(8), .OPW(3)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .RD1(a8), .RD2(b8), .INop(op8), .out_valid(ov8), .out_ready(or8),
    .WD(wd8), .Cout(c8), .V(v8), .Z(z8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sx(input longint unsigned x, input int w);
    return ((x >> (w - 1)) & 1) != 0 ? longint'(x) - (longint'(1) << w) : longint'(x);
  endfunction

  // Reference ALU: plain integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input longint unsigned a_in,
                                 input longint unsigned b_in, input logic [2:0] op);
    longint unsigned mask = (longint'(1) << w) - 1;
    longint unsigned a = a_in & mask;
    longint unsigned b = b_in & mask;
    longint sa = sx(a, w);
    longint sb = sx(b, w);
    longint smax = (longint'(1) << (w - 1)) - 1;
    longint smin = -(longint'(1) << (w - 1));
    longint sr;
    longint unsigned r = 0;
    exp_t e;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r   = a + b;
        e.c = ((a + b) >> w) != 0;
        sr  = sa + sb;
        e.v = (sr > smax) || (sr < smin);
      end
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b101: r = (a < b) ? 1 : 0;
      3'b110: begin
        r   = a - b;
        e.c = (a >= b);
        sr  = sa - sb;
        e.v = (sr > smax) || (sr < smin);
      end
      default: r = (sa < sb) ? 1 : 0;
    endcase
    r     = r & mask;
    e.res = 32'(r);
    e.z   = (r == 0);
    return e;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    logic [31:0] msb  = 32'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return mask;
      2:       return msb;
      3:       return msb - 32'd1;
      4:       return 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  // Scoreboards: sampled on the falling edge, each captures the transfers of the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q32.delete();
      hold32 <= 1'b0;
    end else begin
      if (hold32) check("hold32", {ov32, wd32, c32, v32, z32}, {1'b1, held32});
      if (ov32 && or32) begin
        check("out_has_op32", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("res32", {wd32, c32, v32, z32}, e);
        end
      end
      if (iv32 && ir32) begin
        q32.push_back(model(32, a32, b32, op32));
        acc32 <= acc32 + 1;
      end
      hold32 <= ov32 && !or32;
      held32 <= {wd32, c32, v32, z32};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q8.delete();
      hold8 <= 1'b0;
    end else begin
      if (hold8) check("hold8", {ov8, wd8, c8, v8, z8}, {1'b1, held8[10:0]});
      if (ov8 && or8) begin
        check("out_has_op8", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check("res8", {24'd0, wd8, c8, v8, z8}, e);
        end
      end
      if (iv8 && ir8) q8.push_back(model(8, 64'(a8), 64'(b8), op8));
      hold8 <= ov8 && !or8;
      held8 <= {24'd0, wd8, c8, v8, z8};
    end
  end

  task automatic drive(input logic w8, input logic valid, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      iv8 = valid; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = valid; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic observe(input logic w8, output logic ov, output logic [34:0] r);
    if (w8) begin
      ov = ov8;
      r  = {24'd0, wd8, c8, v8, z8};
    end else begin
      ov = ov32;
      r  = {wd32, c32, v32, z32};
    end
  endtask

  // Back-to-back ops from vt[0..n-1] into an empty pipe; op i must appear two cycles later.
  task automatic run_burst(input logic w8, input int n, input string tag);
    logic ov;
    logic [34:0] r;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i < n) drive(w8, 1'b1, vt[i].op, vt[i].a, vt[i].b);
      else       drive(w8, 1'b0, 3'b000, 32'd0, 32'd0);
      if (i >= 2) begin
        observe(w8, ov, r);
        check({tag, "_valid"}, ov, 1);
        check({tag, "_res"}, r, {vt[i-2].wd, vt[i-2].c, vt[i-2].v, vt[i-2].z});
      end
    end
  endtask

  initial begin
    int a0;
    int budget;
    reset = 1'b1;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; op8  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_ov32", ov32, 0);
    check("rst_out32", {wd32, c32, v32, z32}, 0);
    check("rst_ir32", ir32, 1);
    check("rst_ov8", ov8, 0);
    check("rst_out8", {wd8, c8, v8, z8}, 0);

    // Back-to-back with out_ready high.
    vt[0] = '{ADD_OP, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[1] = '{SUB_OP, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1'b1};
    vt[2] = '{SLT_OP, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0};
    vt[3] = '{AND_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    run_burst(1'b0, 4, "b2b");

    // Carry / overflow corners.
    vt[0] = '{ADD_OP,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1};
    vt[1] = '{SUB_OP,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[2] = '{SLTU_OP, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0};
    run_burst(1'b0, 3, "cv");

    // Narrow instance corners.
    vt[0] = '{ADD_OP, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, 1'b0};
    vt[1] = '{SLT_OP, 32'h80, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0};
    run_burst(1'b1, 2, "w8");

    // Bubbles: in_valid 1,0,1 -> out_valid 1,0,1 two cycles later.
    @(posedge clk); #1 drive(1'b0, 1'b1, ADD_OP, 32'd3, 32'd4);
    @(posedge clk); #1 drive(1'b0, 1'b0, ADD_OP, 32'd0, 32'd0);
    check("bub_ov0", ov32, 0);
    @(posedge clk); #1 drive(1'b0, 1'b1, XOR_OP, 32'h0000_FF00, 32'h0000_0F0F);
    check("bub_ov1", ov32, 1);
    check("bub_wd1", wd32, 32'd7);
    @(posedge clk); #1 drive(1'b0, 1'b0, ADD_OP, 32'd0, 32'd0);
    check("bub_ov2", ov32, 0);
    check("bub_wd2", wd32, 32'd7);
    @(posedge clk); #1;
    check("bub_ov3", ov32, 1);
    check("bub_wd3", wd32, 32'h0000_F00F);
    @(posedge clk); #1;
    check("bub_ov4", ov32, 0);

    // Backpressure: out_ready low for four cycles with in_valid high.
    @(posedge clk); #1;
    a0 = acc32;
    or32 = 1'b0;
    drive(1'b0, 1'b1, ADD_OP, 32'd10, 32'd20);
    @(posedge clk); #1 drive(1'b0, 1'b1, SUB_OP, 32'd100, 32'd1);
    check("bp_ir_e1", ir32, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_ir", ir32, 0);
      check("bp_ov", ov32, 1);
      check("bp_wd", wd32, 32'd30);
    end
    check("bp_accepted", acc32 - a0, 2);
    or32 = 1'b1;
    drive(1'b0, 1'b0, ADD_OP, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("bp_drain_ov", ov32, 1);
    check("bp_drain_wd", wd32, 32'd99);
    @(posedge clk); #1;
    check("bp_empty_ov", ov32, 0);

    // Reset with two ops in flight.
    @(posedge clk); #1 drive(1'b0, 1'b1, SUB_OP, 32'h8000_0000, 32'h1);
    @(posedge clk); #1 drive(1'b0, 1'b1, ADD_OP, 32'd1, 32'd2);
    @(posedge clk); #1 drive(1'b0, 1'b0, ADD_OP, 32'd0, 32'd0);
    check("pre_rst_ov", ov32, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ov", ov32, 0);
    check("mid_rst_out", {wd32, c32, v32, z32}, 0);
    check("mid_rst_ir", ir32, 1);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_ov", ov32, 0);
      check("post_rst_ir", ir32, 1);
    end

    // Random traffic on both widths with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      drive(1'b0, $urandom_range(0, 3) != 0, 3'($urandom), rnd(32), rnd(32));
      drive(1'b1, $urandom_range(0, 3) != 0, 3'($urandom), rnd(8), rnd(8));
      or32 = $urandom_range(0, 9) < 7;
      or8  = $urandom_range(0, 9) < 6;
    end

    // Drain with a bounded wait.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    or32 = 1'b1;
    or8  = 1'b1;
    budget = 0;
    while ((q32.size() != 0 || q8.size() != 0) && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain32", q32.size(), 0);
    check("drain8", q8.size(), 0);
    check("final_ov32", ov32, 0);
    check("final_ov8", ov8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised successor to the fixed 32-bit, free-running two-register ALU pipe.
- Two-stage ALU pipeline (operand/op capture, then execute/result capture) with valid/ready handshaking, backpressure and registered flags.
- Sits between register-file read and writeback. Supports stalls without dropping or duplicating operations.

Parameters:
- WIDTH, 32, datapath width in bits (must be >= 2)
- OPW, 3, opcode width (fixed encoding below, so must be 3)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/op presented this cycle
- in_ready  output  1  stage 1 can accept this cycle
- RD1  input  WIDTH  operand a
- RD2  input  WIDTH  operand b
- INop  input  OPW  ALU operation
- out_valid  output  1  WD/flags hold a valid result
- out_ready  input  1  consumer takes result this cycle
- WD  output  WIDTH  result
- Cout  output  1  carry flag
- V  output  1  signed overflow flag
- Z  output  1  zero flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values:
  - s1_valid=0, out_valid=0.
  - WD=0, Cout=0, V=0, Z=0.
  - Stage-1 data registers=0.
  - Reset asserted mid-operation discards all in-flight ops immediately; nothing emerges after release.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Stage 2 (output) load enable: s2_en = !out_valid | out_ready.
  - On s2_en: out_valid <= s1_valid. If s1_valid, WD/Cout/V/Z <= ALU(s1 regs).
  - Output data registers change only when s2_en and s1_valid. Otherwise they hold, stable while out_valid & !out_ready.
- Stage 1 load enable: s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational from out_valid, out_ready, s1_valid; no path from in_valid).
  - On s1_en: s1_valid <= in_valid. If in_valid, capture RD1, RD2, INop.
- Latency and throughput:
  - Accepted at edge N -> out_valid visible after edge N+1 (2-register latency, same as the predecessor).
  - Full throughput: 1 op/cycle when out_ready is held high.
  - Simultaneous accept/emit in a full pipe is legal: both stages advance in the same cycle.
  - Stall with the pipe full: in_ready=0 and both stages hold.
- Opcode encoding (a, b from stage 1; arithmetic modulo 2^WIDTH):
  - 000 AND
  - 001 OR
  - 010 ADD: a+b
  - 011 XOR
  - 100 NOR
  - 101 SLTU: {0..,a<b unsigned}
  - 110 SUB: a+~b+1
  - 111 SLT: {0..,a<b signed}
- Flags:
  - Cout = carry out of bit WIDTH-1 for ADD and SUB; for SUB, Cout=1 means no borrow (a>=b unsigned). Cout=0 for all other ops.
  - V = signed overflow for ADD (operand signs equal, result sign differs) and SUB (operand signs differ, result sign differs from a). V=0 for all other ops.
  - SLT uses the true signed compare (sign of the difference XOR overflow), not the raw sign bit.
  - Z = (result == 0) for all ops.

Test Plan:
- Reset mid-stream: two ops in flight, assert reset -> out_valid=0, WD=0, flags 0 immediately. After release, no stale result appears and in_ready=1.
- Back-to-back, out_ready=1: ADD 0x7FFFFFFF+1, SUB 5-5, SLT 0xFFFFFFFF vs 1, AND 0xF0F0F0F0&0x0FF00FF0 on consecutive cycles -> consecutive results:
  - 0x80000000 with V=1, C=0, Z=0
  - 0 with Z=1, C=1, V=0
  - 1
  - 0x00F000F0
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 ops accepted, then in_ready=0. WD holds the first result. After out_ready=1, results drain in order with no loss or duplication.
- Bubbles: in_valid toggling 1,0,1 with out_ready=1 -> out_valid pattern 1,0,1 delayed 2 cycles. WD unchanged during the bubble.
- Carry/overflow: ADD 0xFFFFFFFF+1 -> WD=0, C=1, Z=1, V=0. SUB 0x80000000-1 -> 0x7FFFFFFF, V=1, C=1. SLTU 1 vs 0xFFFFFFFF -> 1.
- WIDTH=8 instance: ADD 0x7F+0x01 -> 0x80, V=1. SLT 0x80 vs 0x7F -> 1. Random stream compared against a reference model with random out_ready.
